// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for an I2C master: latches the winner's
// transfer, pulses the master start, waits for done or timeout, then strobes a response.
module i2c_req_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  rw0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  rw1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  m_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  r_w,
    output logic [DATA_WIDTH-1:0] f_out,
    input  logic                  ack_n,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  sel_q, sel_d;
    logic                  last_q, last_d;
    logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d, m_en_q, m_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  r_w_q, r_w_d;
    logic [DATA_WIDTH-1:0] f_out_q, f_out_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  busy_q, busy_d;
    logic                  pick;

    // last_q holds the requester served most recently; the other one wins a tie.
    assign pick = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        addr_d      = addr_q;
        r_w_d       = r_w_q;
        f_out_d     = f_out_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        m_en_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    sel_d   = pick;
                    addr_d  = pick ? addr1 : addr0;
                    r_w_d   = pick ? rw1 : rw0;
                    f_out_d = pick ? wdata1 : wdata0;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    m_en_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = sel_q;
                    rsp_err_d   = ack_n;
                    rsp_data_d  = (r_w_q && !ack_n) ? rdata : '0;
                    state_d     = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = sel_q;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            m_en_q      <= 1'b0;
            addr_q      <= '0;
            r_w_q       <= 1'b0;
            f_out_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            m_en_q      <= m_en_d;
            addr_q      <= addr_d;
            r_w_q       <= r_w_d;
            f_out_q     <= f_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign m_en      = m_en_q;
    assign addr      = addr_q;
    assign r_w       = r_w_q;
    assign f_out     = f_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 7: I2C target address width.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8: transfer data width.
REQ-003 The block SHALL take parameter TIMEOUT, default 255: maximum WAIT cycles before abort, legal range 2..255.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  transaction request, requester 0 (functional unit).
- addr0  in  ADDR_WIDTH  target address, requester 0.
- rw0  in  1  1 = read, 0 = write, requester 0.
- wdata0  in  DATA_WIDTH  write data, requester 0.
- req1, addr1, rw1, wdata1  in  1/ADDR_WIDTH/1/DATA_WIDTH  same as above, requester 1 (host).
- gnt0, gnt1  out  1  one-cycle accept pulse to the selected requester.
- m_en  out  1  one-cycle start pulse to the I2C master.
- addr  out  ADDR_WIDTH  latched address to the master.
- r_w  out  1  latched direction to the master.
- f_out  out  DATA_WIDTH  latched write data to the master.
- ack_n  in  1  slave acknowledge, low = ACK.
- done  in  1  slave transaction-complete indication.
- rdata  in  DATA_WIDTH  slave read data (data_out).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  requester served by this response.
- rsp_err  out  1  1 = NACK or timeout.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 The block SHALL implement the states IDLE, ISSUE, WAIT and RESP, with all outputs registered.
REQ-006 In IDLE with any reqX high at a clock edge, the block SHALL select one requester, latch that requester's addr, rw and wdata into addr, r_w and f_out, and enter ISSUE.
REQ-007 Selection SHALL be round-robin: when both requests are high, the requester not served last wins; after reset, requester 0 wins.
REQ-008 In ISSUE, which lasts exactly one cycle, the block SHALL drive m_en=1 and gntX=1 for the selected requester only, then enter WAIT with the timeout counter at 0.
REQ-009 Each requester SHALL hold reqX and its fields stable until gntX; the block SHALL ignore field changes after the latch.
REQ-010 addr, r_w and f_out SHALL remain stable from ISSUE through RESP.
REQ-011 In WAIT, done=1 SHALL end the transaction and the block SHALL enter RESP.
- rsp_err = ack_n.
- rsp_data = rdata if r_w=1 and ack_n=0, otherwise 0.
REQ-012 In WAIT, each cycle without done SHALL increment the counter; when the counter reaches TIMEOUT-1 without done, the block SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-013 If done and timeout occur in the same cycle, done SHALL take priority.
REQ-014 done asserted during IDLE, ISSUE or RESP SHALL be ignored.
REQ-015 In RESP, which lasts one cycle, rsp_valid SHALL be 1, with rsp_id equal to the served requester; the round-robin pointer SHALL update and the block SHALL return to IDLE.
REQ-016 Requests present during RESP SHALL be evaluated in the following IDLE cycle, giving a minimum of 1 idle cycle between transactions.
REQ-017 Minimum latency from request to response SHALL be:
- req sampled in IDLE at edge N, then ISSUE at N+1;
- WAIT at N+2;
- done at N+2, then rsp_valid at N+3.
REQ-018 The counter SHALL be 8 bits wide and SHALL NOT wrap within a transaction.

Reset
REQ-019 Asserting reset SHALL immediately force the following, regardless of clock:
- state = IDLE and counter = 0;
- round-robin pointer set to favour requester 0;
- all outputs 0: gnt0, gnt1, m_en, addr, r_w, f_out, rsp_valid, rsp_id, rsp_err, rsp_data and busy.
REQ-020 Reset asserted mid-transaction SHALL abort it with no rsp_valid; the requester SHALL re-request.
REQ-021 After reset deasserts, the first rising edge with a request high SHALL begin arbitration.

Verification
REQ-022 Single write test: req0=1, addr0=7'h50, rw0=0, wdata0=8'hA5, done=1 with ack_n=0 two cycles after ISSUE -> the bench SHALL see gnt0 and m_en high in the same cycle, addr=7'h50, f_out=8'hA5, then rsp_valid=1, rsp_id=0, rsp_err=0, rsp_data=0.
REQ-023 Read test: req1=1, addr1=7'h50, rw1=1, done=1 with ack_n=0 and rdata=8'h3C -> the bench SHALL see rsp_id=1, rsp_err=0, rsp_data=8'h3C.
REQ-024 Contention test: req0 and req1 held high for 3 transactions -> the bench SHALL see a grant order of 0, 1, 0.
REQ-025 Timeout test: TIMEOUT=4 with done never asserted -> the bench SHALL see rsp_valid with rsp_err=1 exactly 4 cycles after WAIT entry, followed by busy=0.
REQ-026 NACK test: done=1 with ack_n=1 on a read with rdata=8'hFF -> the bench SHALL see rsp_err=1 and rsp_data=0.
REQ-027 Reset-in-WAIT test: reset pulsed while in WAIT -> the bench SHALL see all outputs at 0, no rsp_valid, and the next simultaneous request granted to requester 0.
